// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 800x600 SVGA @ 50 MHz raster timing constants
package vga_timing_pkg;

  localparam int ADDR_W = 11;

  localparam int H_SYNC_DEF   = 120;
  localparam int H_BACK_DEF   = 64;
  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FRONT_DEF  = 56;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BACK_DEF   = 23;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FRONT_DEF  = 37;

  localparam int H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;
  localparam int V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;
  localparam int H_START_DEF = H_SYNC_DEF + H_BACK_DEF;
  localparam int V_START_DEF = V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping raster position counter with sync and active window decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL  = H_TOTAL_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int START  = H_START_DEF,
  parameter int ACTIVE = H_ACTIVE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              wrap,
  output logic              in_sync,
  output logic              in_active,
  output logic [ADDR_W-1:0] offset
);

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] SYNC_END = ADDR_W'(SYNC);
  localparam logic [ADDR_W-1:0] ACT_BEG  = ADDR_W'(START);
  localparam logic [ADDR_W-1:0] ACT_END  = ADDR_W'(START + ACTIVE);

  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
    end
  end

  assign wrap      = en && (cnt == LAST);
  assign in_sync   = (cnt < SYNC_END);
  assign in_active = (cnt >= ACT_BEG) && (cnt < ACT_END);
  // Only meaningful while in_active; the caller gates it, so wrap-around below START is harmless.
  assign offset    = cnt - ACT_BEG;

endmodule

// File: rtl/vga_sync_module.sv
// rtl/vga_sync_module.sv - VGA raster timing: hsync/vsync, active qualifier, pixel column/row
// Optional VGA_FRAME_TICK_EN adds frame_tick/frame_cnt for the falling-piece gravity timer.
module vga_sync_module
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              hsync,
  output logic              vsync,
  output logic              ready_sig,
  output logic [ADDR_W-1:0] col_addr_sig,
  output logic [ADDR_W-1:0] row_addr_sig
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic              frame_tick,
  output logic [7:0]        frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  logic              line_end, frame_end;
  logic              h_sync_win, v_sync_win, h_act, v_act, active;
  logic [ADDR_W-1:0] h_off, v_off;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .SYNC  (H_SYNC),
    .START (H_START),
    .ACTIVE(H_ACTIVE)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .wrap     (line_end),
    .in_sync  (h_sync_win),
    .in_active(h_act),
    .offset   (h_off)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .SYNC  (V_SYNC),
    .START (V_START),
    .ACTIVE(V_ACTIVE)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (line_end),
    .wrap     (frame_end),
    .in_sync  (v_sync_win),
    .in_active(v_act),
    .offset   (v_off)
  );

  assign active = h_act && v_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      ready_sig    <= 1'b0;
      col_addr_sig <= '0;
      row_addr_sig <= '0;
    end else begin
      hsync        <= h_sync_win ? SYNC_POL : ~SYNC_POL;
      vsync        <= v_sync_win ? SYNC_POL : ~SYNC_POL;
      ready_sig    <= active;
      col_addr_sig <= active ? h_off : '0;
      row_addr_sig <= active ? v_off : '0;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // at_origin mirrors "counters sit at h=0, v=0"; true straight out of reset as well.
  logic at_origin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_origin  <= 1'b1;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      at_origin  <= frame_end;
      frame_tick <= at_origin;
      frame_cnt  <= frame_cnt + {7'd0, frame_tick};
    end
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// tb/tb_vga_sync_module.sv - bench: default-timing first lines plus a shrunk-timing instance for frame corners
`timescale 1ns/1ps
module tb_vga_sync_module;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        rdy;
    logic [10:0] col;
    logic [10:0] row;
  } out_t;

  typedef struct {
    int   k;
    out_t exp;
  } vec_t;

  localparam int DEF_CYC = 31 * 1040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_s;
  logic d_hs, d_vs, d_rdy, s_hs, s_vs, s_rdy;
  logic [10:0] d_col, d_row, s_col, s_row;
`ifdef VGA_FRAME_TICK_EN
  logic d_tick, s_tick;
  logic [7:0] d_fcnt, s_fcnt;
`endif

  int checks = 0;
  int errors = 0;
  vec_t tbl[14];

  vga_sync_module u_def (
    .clk         (clk),
    .rst_n       (rst_d),
    .hsync       (d_hs),
    .vsync       (d_vs),
    .ready_sig   (d_rdy),
    .col_addr_sig(d_col),
    .row_addr_sig(d_row)
`ifdef VGA_FRAME_TICK_EN
    ,
    .frame_tick  (d_tick),
    .frame_cnt   (d_fcnt)
`endif
  );

  // H: 3+2+4+2 = 11 clocks, V: 2+1+3+1 = 7 lines, active-low syncs.
  vga_sync_module #(
    .H_SYNC(3), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .SYNC_POL(1'b0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_s),
    .hsync       (s_hs),
    .vsync       (s_vs),
    .ready_sig   (s_rdy),
    .col_addr_sig(s_col),
    .row_addr_sig(s_row)
`ifdef VGA_FRAME_TICK_EN
    ,
    .frame_tick  (s_tick),
    .frame_cnt   (s_fcnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic out_t model(input int p, input int hsw, input int hb, input int ha, input int hf,
                                 input int vsw, input int vb, input int va, input int vf, input logic pol);
    int   ht, vt, h, v;
    out_t o;
    ht    = hsw + hb + ha + hf;
    vt    = vsw + vb + va + vf;
    h     = p % ht;
    v     = (p / ht) % vt;
    o.hs  = (h < hsw) ? pol : ~pol;
    o.vs  = (v < vsw) ? pol : ~pol;
    o.rdy = (h >= hsw + hb) && (h < hsw + hb + ha) && (v >= vsw + vb) && (v < vsw + vb + va);
    o.col = o.rdy ? 11'(h - hsw - hb) : 11'd0;
    o.row = o.rdy ? 11'(v - vsw - vb) : 11'd0;
    return o;
  endfunction

  task automatic run_small(input string tag);
    int   idx  = 0;
    int   mism = 0;
    int   ticks = 0;
    out_t cur, e;
    for (int k = 1; k <= 116; k++) begin
      @(posedge clk);
      #1;
      cur = {s_hs, s_vs, s_rdy, s_col, s_row};
      e   = model(k - 1, 3, 2, 4, 2, 2, 1, 3, 1, 1'b0);
      if (cur !== e) mism++;
`ifdef VGA_FRAME_TICK_EN
      if (s_tick) ticks++;
      if (k == 1) check($sformatf("%s_fcnt_start", tag), s_fcnt, 0);
`endif
      if (idx < 14 && tbl[idx].k == k) begin
        check($sformatf("%s_k%0d_hsync", tag, k), s_hs,  tbl[idx].exp.hs);
        check($sformatf("%s_k%0d_vsync", tag, k), s_vs,  tbl[idx].exp.vs);
        check($sformatf("%s_k%0d_ready", tag, k), s_rdy, tbl[idx].exp.rdy);
        check($sformatf("%s_k%0d_col",   tag, k), s_col, tbl[idx].exp.col);
        check($sformatf("%s_k%0d_row",   tag, k), s_row, tbl[idx].exp.row);
        idx++;
      end
    end
    check($sformatf("%s_model_mismatches", tag), mism, 0);
    check($sformatf("%s_vectors_applied", tag), idx, 14);
`ifdef VGA_FRAME_TICK_EN
    check($sformatf("%s_frame_ticks", tag), ticks, 2);
    check($sformatf("%s_fcnt_end", tag), s_fcnt, 2);
`else
    check($sformatf("%s_no_ticks", tag), ticks, 0);
`endif
  endtask

  initial begin
    int   mism = 0, hs_hi = 0, vs_hi = 0, rdy_hi = 0, rdy_rises = 0, step_err = 0;
    int   first_rdy = 0, fall_k = 0, last_col = 0, hs_rise0 = 0, hs_rise1 = 0;
    logic prev_hs = 1'b0, prev_rdy = 1'b0;
    logic [10:0] prev_col = '0;
    out_t cur, e;

    //           k     hs    vs    rdy   col    row
    tbl[0]  = '{1,   '{1'b0, 1'b0, 1'b0, 11'd0, 11'd0}};
    tbl[1]  = '{3,   '{1'b0, 1'b0, 1'b0, 11'd0, 11'd0}};
    tbl[2]  = '{4,   '{1'b1, 1'b0, 1'b0, 11'd0, 11'd0}};
    tbl[3]  = '{12,  '{1'b0, 1'b0, 1'b0, 11'd0, 11'd0}};
    tbl[4]  = '{23,  '{1'b0, 1'b1, 1'b0, 11'd0, 11'd0}};
    tbl[5]  = '{39,  '{1'b1, 1'b1, 1'b1, 11'd0, 11'd0}};
    tbl[6]  = '{42,  '{1'b1, 1'b1, 1'b1, 11'd3, 11'd0}};
    tbl[7]  = '{43,  '{1'b1, 1'b1, 1'b0, 11'd0, 11'd0}};
    tbl[8]  = '{50,  '{1'b1, 1'b1, 1'b1, 11'd0, 11'd1}};
    tbl[9]  = '{61,  '{1'b1, 1'b1, 1'b1, 11'd0, 11'd2}};
    tbl[10] = '{64,  '{1'b1, 1'b1, 1'b1, 11'd3, 11'd2}};
    tbl[11] = '{65,  '{1'b1, 1'b1, 1'b0, 11'd0, 11'd0}};
    tbl[12] = '{78,  '{1'b0, 1'b0, 1'b0, 11'd0, 11'd0}};
    tbl[13] = '{116, '{1'b1, 1'b1, 1'b1, 11'd0, 11'd0}};

    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("def_reset_hsync", d_hs, 0);
    check("def_reset_vsync", d_vs, 0);
    check("def_reset_ready", d_rdy, 0);
    check("small_reset_hsync", s_hs, 1);

    // Default 800x600 timing over the first 31 lines (rows 0 and 1 of the active area).
    @(negedge clk);
    rst_d = 1'b1;
    for (int k = 1; k <= DEF_CYC; k++) begin
      @(posedge clk);
      #1;
      cur = {d_hs, d_vs, d_rdy, d_col, d_row};
      e   = model(k - 1, 120, 64, 800, 56, 6, 23, 600, 37, 1'b1);
      if (cur !== e) mism++;
      if (k == 1) check("def_first_edge_hsync", d_hs, 1);
      if (d_hs && !prev_hs) begin
        if (hs_rise0 == 0) hs_rise0 = k;
        else if (hs_rise1 == 0) hs_rise1 = k;
      end
      if (k <= 1040 && d_hs) hs_hi++;
      if (d_vs) vs_hi++;
      if (d_rdy && !prev_rdy) begin
        rdy_rises++;
        if (first_rdy == 0) begin
          first_rdy = k;
          check("def_first_active_col", d_col, 0);
          check("def_first_active_row", d_row, 0);
        end
      end
      if (d_rdy) begin
        rdy_hi++;
        if (prev_rdy && d_col !== prev_col + 11'd1) step_err++;
      end
      if (!d_rdy && prev_rdy && fall_k == 0) begin
        fall_k   = k;
        last_col = int'(prev_col);
        check("def_col_after_fall", d_col, 0);
      end
      prev_hs  = d_hs;
      prev_rdy = d_rdy;
      prev_col = d_col;
    end
    check("def_model_mismatches", mism, 0);
    check("def_hsync_width", hs_hi, 120);
    check("def_hsync_first_rise", hs_rise0, 1);
    check("def_hsync_period", hs_rise1 - hs_rise0, 1040);
    check("def_vsync_width", vs_hi, 6240);
    check("def_first_ready_edge", first_rdy, 29 * 1040 + 185);
    check("def_ready_fall_edge", fall_k, 29 * 1040 + 185 + 800);
    check("def_last_col", last_col, 799);
    check("def_col_step_errors", step_err, 0);
    check("def_active_lines", rdy_rises, 2);
    check("def_ready_clocks", rdy_hi, 1600);

    // Shrunk timing: table vectors across two frames, including the frame wrap.
    @(negedge clk);
    rst_s = 1'b1;
    run_small("small");

    // Mid-frame asynchronous reset while in the active area (h=7, v=3).
    repeat (2) @(posedge clk);
    #3;
    rst_s = 1'b0;
    #1;
    check("midrst_hsync", s_hs, 1);
    check("midrst_vsync", s_vs, 1);
    check("midrst_ready", s_rdy, 0);
    check("midrst_col", s_col, 0);
    check("midrst_row", s_row, 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_hold", {s_hs, s_vs, s_rdy, s_col, s_row}, {3'b110, 22'd0});
    @(negedge clk);
    rst_s = 1'b1;
    run_small("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_module.md
Name: vga_sync_module

Overview:
- Generates VGA raster timing for the Tetris display: horizontal and vertical sync, an active-video qualifier, and the pixel column/row addresses.
- Default mode is 800x600 SVGA at 50 MHz pixel clock.
- Its col_addr_sig/row_addr_sig/ready_sig outputs feed every downstream enable and colour module, e.g. border, playfield and next-piece.
- hsync/vsync drive the VGA connector directly.

Parameters:
- H_SYNC, 120, hsync pulse width in clocks
- H_BACK, 64, horizontal back porch in clocks
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch in clocks
- V_SYNC, 6, vsync pulse width in lines
- V_BACK, 23, vertical back porch in lines
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch in lines
- SYNC_POL, 1'b1, asserted level of hsync/vsync

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- ready_sig  output  1  high while the current pixel is in the active area
- col_addr_sig  output  11  active-area column, 0..H_ACTIVE-1; 0 outside the active area
- row_addr_sig  output  11  active-area row, 0..V_ACTIVE-1; 0 outside the active area

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - h_cnt=0, v_cnt=0
  - hsync=~SYNC_POL, vsync=~SYNC_POL
  - ready_sig=0, col_addr_sig=0, row_addr_sig=0
- Derived constants:
  - H_TOTAL=H_SYNC+H_BACK+H_ACTIVE+H_FRONT (1040)
  - V_TOTAL=V_SYNC+V_BACK+V_ACTIVE+V_FRONT (666)
  - H_START=H_SYNC+H_BACK (184)
  - V_START=V_SYNC+V_BACK (29)
- h_cnt (11 bit):
  - increments every clock.
  - At H_TOTAL-1 it wraps to 0 and issues line_end.
- v_cnt (11 bit):
  - increments only on line_end.
  - At V_TOTAL-1 with line_end it wraps to 0.
- All outputs are registered decodes of the current counters, so outputs lag the counters by exactly 1 clock.
  - The k-th rising edge after reset release (k>=1) presents position h=(k-1) mod H_TOTAL on the outputs.
- hsync = SYNC_POL when h_cnt < H_SYNC, else ~SYNC_POL.
- vsync = SYNC_POL when v_cnt < V_SYNC, else ~SYNC_POL. vsync changes only at line boundaries.
- ready_sig = 1 when H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE.
- When ready_sig=1:
  - col_addr_sig = h_cnt-H_START
  - row_addr_sig = v_cnt-V_START
- When ready_sig=0, both addresses are forced to 0.
- Subtraction is 11-bit unsigned; it never underflows because it is gated by the range checks.
- Addresses are monotonic within a line/frame. col_addr_sig steps by exactly 1 per clock while ready_sig=1.
- Boundaries:
  - Last active pixel (col 799, row 599) is followed by ready_sig=0 and col_addr_sig=0.
  - Frame wrap returns to h=0, v=0 with hsync and vsync both asserted on the same cycle.
- Reset asserted mid-frame: all registers clear immediately. After release, timing restarts from h=0, v=0 with no partial-line artefacts.
- No input handshake: the block is free-running and never stalls.

Optional Feature:
- Macro: VGA_FRAME_TICK_EN.
- Defined:
  - Adds output frame_tick (1 bit). It is a single-clock pulse on the cycle the outputs present h=0, v=0, i.e. one pulse per frame.
  - Adds output frame_cnt (8 bit). It increments on each frame_tick, wraps 255->0, and resets to 0.
  - Used for the falling-piece gravity timer.
- Undefined: neither port exists and the associated logic is absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants
  - derived H_TOTAL/V_TOTAL/H_START/V_START
  - the 11-bit address width constant
- Sub-module vga_axis_counter: a generic wrap counter with enable, sync-window decode and active-window decode.
  - Instantiated twice: horizontal with enable=1, vertical with enable=line_end.

Test Plan:
- Reset release -> first output edge shows hsync=SYNC_POL (h=0). hsync asserted for exactly 120 clocks, period 1040 clocks.
- First active pixel:
  - ready_sig rises 185 clocks after line start output, with col_addr_sig=0 and row_addr_sig=0 at v=29.
  - ready_sig stays high 800 clocks, col_addr_sig runs 0..799.
  - ready_sig then falls and col_addr_sig=0.
- vsync asserted for exactly 6*1040=6240 clocks, period 666*1040=692640 clocks. Exactly 600 lines per frame have ready_sig pulses.
- Force rst_n low at h=500, v=300 for 3 clocks -> all outputs at reset values immediately. After release, the sequence restarts identically to the first test.
- Run 2 frames and check the frame wrap -> row_addr_sig 599 is followed by 0 in the next frame.
  - With VGA_FRAME_TICK_EN: one frame_tick per 692640 clocks, and frame_cnt goes 0->1->2.
- Monitor col_addr_sig=300..520 and row_addr_sig=50..330 windows -> the windows occur at the expected clock offsets. Checked against a downstream border-enable instance.
